counter_sequencer: RTL and testbench

- Run-mode controller for the 1 Hz mod-8 up-counter datapath.
- Replaces the derived slow clock with a single-cycle clock-enable TICK on the system clock.
- Debounces one push-button and steps an FSM: IDLE → UP → DOWN → PAUSE → IDLE.
- Drives the counter's enable, direction and clear, with optional ping-pong reversal at the count limits.

---
 rtl/counter_sequencer_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 75 +++++++
 rtl/counter_sequencer.sv | 138 +++++++++++++
 tb/tb_counter_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg
//   Shared definitions for the run-mode controller of the mod-2^WIDTH
//   up/down counter: the 2-bit run-state encodings and a ceil(log2)
//   helper that sizes the prescaler and debounce counters.
package counter_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_UP    = 2'd1;
  localparam logic [1:0] ST_DOWN  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_UP    = ST_UP,
    S_DOWN  = ST_DOWN,
    S_PAUSE = ST_PAUSE
  } run_state_e;

  // Number of bits needed to hold the values 0..value-1 (0 for value<=1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Push-button conditioner: 2-FF synchronizer, stability counter and a
//   one-cycle pulse on each accepted rising edge.
//   Ports:
//     CLK    system clock
//     RST    synchronous active-high reset
//     BTN    raw asynchronous button, active-high
//     LEVEL  debounced button level
//     PRESS  one-cycle pulse, DEB_CYCLES+3 cycles after a clean BTN rise
module btn_debounce
  import counter_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = (clog2(DEB_CYCLES) < 1) ? 1 : clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          btn_p0, btn_p1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  // ---- stage p0/p1: metastability synchronizer (carries data only, no reset)
  always_ff @(posedge CLK) begin
    btn_p0 <= BTN;
    btn_p1 <= btn_p0;
  end

  // ---- stability counter, level register and edge pulse
  always_comb begin
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    // A button held through reset must be released once before it can
    // generate a press, so presses are only armed after a low sample.
    armed_d     = armed_q | ~btn_p1;
    press_d     = level_q & ~level_dly_q & armed_q;
    if (btn_p1 != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = btn_p1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run-mode controller for a WIDTH-bit up/down counter. A debounced button
//   steps IDLE -> UP -> DOWN -> PAUSE -> IDLE; a prescaler produces a
//   single-cycle TICK every TICK_DIV clocks while running; optional
//   ping-pong reversal at the count limits.
//   Ports:
//     CLK, RST  system clock, synchronous active-high reset
//     BTN       raw push-button
//     Q         current count fed back from the counter
//     TICK      prescaler pulse (UP/DOWN only)
//     CNT_EN    counter steps on the next edge
//     CNT_UP    step direction (1 = +1, 0 = -1)
//     CNT_CLR   synchronous clear request (asserted in IDLE)
//     STATE     IDLE=0, UP=1, DOWN=2, PAUSE=3
//     LED       running indicator
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int AUTO_REV   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  input  logic [WIDTH-1:0] Q,
  output logic             TICK,
  output logic             CNT_EN,
  output logic             CNT_UP,
  output logic             CNT_CLR,
  output logic [1:0]       STATE,
  output logic             LED
);

  localparam int              PW       = clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] Q_MAX   = '1;

  logic          press_raw;
  logic          btn_level;
  logic          press;
  run_state_e    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          run;
  logic          cnt_en;
  logic          cnt_up;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN),
    .LEVEL (btn_level),
    .PRESS (press_raw)
  );

  // A press is acted on while the debounced button is still down; for
  // DEB_CYCLES > 1 the level cannot drop this soon, so this equals PRESS.
  assign press = press_raw & btn_level;

  // ---- next-state, prescaler and direction logic
  always_comb begin
    run     = (state_q == S_UP) || (state_q == S_DOWN);
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    cnt_up  = 1'b1;

    // Prescaler: counts while running, holds in PAUSE so the tick phase
    // survives a pause, and is forced to zero in IDLE.
    case (state_q)
      S_IDLE:  pre_d = '0;
      S_PAUSE: pre_d = pre_q;
      default: begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    endcase

    // A press swallows a coincident tick.
    cnt_en = tick_q & run & ~press;

    // Press always wins over an automatic reversal.
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_UP;
      end
      S_UP: begin
        if (press) begin
          state_d = S_DOWN;
        end else if ((AUTO_REV != 0) && (Q == Q_MAX) && cnt_en) begin
          cnt_up  = 1'b0;
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        cnt_up = 1'b0;
        if (press) begin
          state_d = S_PAUSE;
        end else if ((AUTO_REV != 0) && (Q == '0) && cnt_en) begin
          cnt_up  = 1'b1;
          state_d = S_UP;
        end
      end
      default: begin
        if (press) state_d = S_IDLE;
      end
    endcase
  end

  // ---- registered control state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  assign TICK    = tick_q;
  assign CNT_EN  = cnt_en;
  assign CNT_UP  = cnt_up;
  assign CNT_CLR = (state_q == S_IDLE);
  assign STATE   = state_q;
  assign LED     = run;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       clk;
  logic       rst, btn;
  logic [2:0] q;
  logic       tick, cnt_en, cnt_up, cnt_clr, led;
  logic [1:0] state;

  logic       rst_w, btn_w;
  logic [2:0] q_w;
  logic       tick_w, cnt_en_w, cnt_up_w, cnt_clr_w, led_w;
  logic [1:0] state_w;

  int n_vec = 0;
  int n_err = 0;

  int exp_q  [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int exp_st [15] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 1};
  int exp_up [15] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  int exp_qw [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};

  counter_sequencer #(
    .WIDTH(3), .TICK_DIV(4), .DEB_CYCLES(3), .AUTO_REV(1)
  ) u_dut (
    .CLK(clk), .RST(rst), .BTN(btn), .Q(q),
    .TICK(tick), .CNT_EN(cnt_en), .CNT_UP(cnt_up), .CNT_CLR(cnt_clr),
    .STATE(state), .LED(led)
  );

  counter_sequencer #(
    .WIDTH(3), .TICK_DIV(4), .DEB_CYCLES(3), .AUTO_REV(0)
  ) u_dut_w (
    .CLK(clk), .RST(rst_w), .BTN(btn_w), .Q(q_w),
    .TICK(tick_w), .CNT_EN(cnt_en_w), .CNT_UP(cnt_up_w), .CNT_CLR(cnt_clr_w),
    .STATE(state_w), .LED(led_w)
  );

  // Behavioural mod-8 counters driven by the sequencer outputs.
  always @(posedge clk) begin
    if (rst || cnt_clr) q <= 3'd0;
    else if (cnt_en)    q <= cnt_up ? q + 3'd1 : q - 3'd1;
  end

  always @(posedge clk) begin
    if (rst_w || cnt_clr_w) q_w <= 3'd0;
    else if (cnt_en_w)      q_w <= cnt_up_w ? q_w + 3'd1 : q_w - 3'd1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; rst_w = 1'b1; btn_w = 1'b0;
    step(2);
    rst = 1'b0; rst_w = 1'b0;
    chk("rst_state",   state,   0);
    chk("rst_clr",     cnt_clr, 1);
    chk("rst_tick",    tick,    0);
    chk("rst_led",     led,     0);
    chk("rst_q",       q,       0);
    chk("rst_en",      cnt_en,  0);
    chk("rst_up",      cnt_up,  1);
    chk("rst_state_w", state_w, 0);
    chk("rst_q_w",     q_w,     0);

    // Two-cycle glitch is rejected.
    btn = 1'b1; step(2); btn = 1'b0; step(8);
    chk("glitch_state", state, 0);
    chk("glitch_level", u_dut.btn_level, 0);

    // Clean press: PRESS 6 cycles after the rise, UP on the next edge.
    btn = 1'b1;
    step(5); chk("press_early", u_dut.press, 0);
    step(1); chk("press_lat6",  u_dut.press, 1);
    chk("press_state_pre", state, 0);
    step(1);
    chk("up_state", state,       1);
    chk("up_led",   led,         1);
    chk("up_clr",   cnt_clr,     0);
    chk("up_press", u_dut.press, 0);
    step(3); btn = 1'b0;
    chk("up_notick", tick, 0);
    step(1);

    // Ping-pong: ticks every 4 cycles, 1..7,6..0,1.
    for (int i = 0; i < 15; i++) begin
      chk("pp_tick", tick,   1);
      chk("pp_en",   cnt_en, 1);
      chk("pp_dir",  cnt_up, exp_up[i]);
      step(1);
      chk("pp_q",     q,     exp_q[i]);
      chk("pp_state", state, exp_st[i]);
      step(3);
    end

    // Collision: press lands on the tick that sees Q=7 in UP.
    step(18); btn = 1'b1;
    step(5);
    chk("col_q_pre",  q,     7);
    chk("col_st_pre", state, 1);
    step(1);
    chk("col_tick",  tick,        1);
    chk("col_press", u_dut.press, 1);
    chk("col_en",    cnt_en,      0);
    chk("col_dir",   cnt_up,      1);
    step(1);
    chk("col_q_hold", q,     7);
    chk("col_state",  state, 2);
    btn = 1'b0;
    step(4);
    chk("col_state_nodbl", state, 2);
    chk("col_q_down",      q,     6);

    // Pause one cycle after a tick; prescaler phase held.
    step(2); btn = 1'b1;
    step(6);
    chk("pse_press", u_dut.press, 1);
    chk("pse_st_pre", state, 2);
    chk("pse_q_pre",  q,     4);
    chk("pse_notick", tick,  0);
    step(1);
    chk("pse_state", state,   3);
    chk("pse_q",     q,       4);
    chk("pse_led",   led,     0);
    chk("pse_clr",   cnt_clr, 0);
    btn = 1'b0;
    step(20);
    chk("pse_state_hold", state,       3);
    chk("pse_q_frozen",   q,           4);
    chk("pse_tick",       tick,        0);
    chk("pse_phase",      u_dut.pre_q, 2);
    btn = 1'b1;
    step(6); chk("idle_press", u_dut.press, 1);
    step(1);
    chk("idle_state", state,   0);
    chk("idle_clr",   cnt_clr, 1);
    chk("idle_led",   led,     0);
    btn = 1'b0;
    step(1);
    chk("idle_q",    q,           0);
    chk("idle_pre",  u_dut.pre_q, 0);
    chk("idle_tick", tick,        0);

    // Reset mid-run with the button held through reset.
    step(8); btn = 1'b1;
    step(6); chk("mr_press", u_dut.press, 1);
    step(1); chk("mr_up", state, 1);
    step(2);
    chk("mr_pre2",  u_dut.pre_q, 2);
    chk("mr_up2",   state,       1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mr_state", state,           0);
    chk("mr_pre",   u_dut.pre_q,     0);
    chk("mr_tick",  tick,            0);
    chk("mr_clr",   cnt_clr,         1);
    chk("mr_led",   led,             0);
    chk("mr_level", u_dut.btn_level, 0);
    chk("mr_q",     q,               0);
    step(20);
    chk("mr_held_state", state,           0);
    chk("mr_held_level", u_dut.btn_level, 1);
    btn = 1'b0;
    step(8);
    chk("mr_rel_state", state,           0);
    chk("mr_rel_level", u_dut.btn_level, 0);
    btn = 1'b1;
    step(6); chk("mr_repress", u_dut.press, 1);
    step(1); chk("mr_re_up",   state,       1);
    btn = 1'b0;

    // AUTO_REV=0: UP wraps 7 -> 0.
    btn_w = 1'b1;
    step(6); chk("w_press", u_dut_w.press, 1);
    step(1); chk("w_up",    state_w,       1);
    btn_w = 1'b0;
    step(4);
    for (int i = 0; i < 8; i++) begin
      chk("w_tick", tick_w,   1);
      chk("w_en",   cnt_en_w, 1);
      chk("w_dir",  cnt_up_w, 1);
      step(1);
      chk("w_q",     q_w,     exp_qw[i]);
      chk("w_state", state_w, 1);
      step(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
